// File: rtl/z80_alu_serial_if.sv
// Start/done handshake and operand/result bus between the execute sequencer
// and the digit-serial ALU.
interface z80_alu_serial_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] operand;
    logic [7:0]       f_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [7:0]       f_out;

    modport master (
        output start, op, a_in, operand, f_in,
        input  busy, done, result, f_out
    );

    modport slave (
        input  start, op, a_in, operand, f_in,
        output busy, done, result, f_out
    );
endinterface

// File: rtl/z80_alu_serial.sv
// Digit-serial Z80 ALU: processes one DIGIT-bit slice per clock, LSB digit first,
// producing the result and {S,Z,5,H,3,V,N,C} flags on a one-cycle done pulse.
module z80_alu_serial #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 4
) (
    input  logic            clk,
    input  logic            reset,
    z80_alu_serial_if.slave bus
);
    // ALU function encoding; 0 is ADD and needs no explicit decode.
    localparam logic [2:0] ALU_ADC = 3'd1;
    localparam logic [2:0] ALU_SUB = 3'd2;
    localparam logic [2:0] ALU_SBC = 3'd3;
    localparam logic [2:0] ALU_AND = 3'd4;
    localparam logic [2:0] ALU_XOR = 3'd5;
    localparam logic [2:0] ALU_OR  = 3'd6;
    localparam logic [2:0] ALU_CP  = 3'd7;

    localparam int N     = WIDTH / DIGIT;
    localparam int CW    = (N > 1) ? $clog2(N) : 1;
    localparam int H_BIT = WIDTH - 5;
    localparam int H_DIG = H_BIT / DIGIT;
    localparam int H_POS = H_BIT % DIGIT;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [CW-1:0]    r_cnt;
    logic [2:0]       r_op;
    logic             r_sub;
    logic             r_carry;
    logic             r_h;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic [WIDTH-1:0] r_result;
    logic [7:0]       r_f_in;
    logic [7:0]       r_f_out;

    logic             w_load;
    logic             w_last;
    logic             w_sub_in;
    logic             w_cin_in;
    logic             w_logic;
    logic [DIGIT-1:0] w_a_dig;
    logic [DIGIT-1:0] w_b_dig;
    logic [DIGIT-1:0] w_add_dig;
    logic [DIGIT-1:0] w_dig;
    logic [DIGIT:0]   w_c;
    logic [WIDTH-1:0] w_value;
    logic [WIDTH-1:0] w_a_rot;
    logic [WIDTH-1:0] w_b_rot;
    logic             w_h_arith;
    logic             w_flag_h;
    logic             w_flag_v;
    logic             w_flag_c;
    logic [7:0]       w_f_next;

    assign w_sub_in = (bus.op == ALU_SUB) || (bus.op == ALU_SBC) || (bus.op == ALU_CP);
    assign w_cin_in = ((bus.op == ALU_ADC) || (bus.op == ALU_SBC)) && bus.f_in[0];
    assign w_load   = bus.start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_last   = (r_cnt == CW'(N - 1));
    assign w_logic  = (r_op == ALU_AND) || (r_op == ALU_XOR) || (r_op == ALU_OR);

    assign w_a_dig = r_a[DIGIT-1:0];
    assign w_b_dig = r_b[DIGIT-1:0];
    assign w_c[0]  = r_carry;

    for (genvar gi = 0; gi < DIGIT; gi++) begin : g_bit
        assign w_add_dig[gi] = w_a_dig[gi] ^ w_b_dig[gi] ^ w_c[gi];
        assign w_c[gi+1]     = (w_a_dig[gi] & w_b_dig[gi]) | (w_c[gi] & (w_a_dig[gi] ^ w_b_dig[gi]));
    end

    always_comb begin
        w_dig = w_add_dig;
        case (r_op)
            ALU_AND: w_dig = w_a_dig & w_b_dig;
            ALU_XOR: w_dig = w_a_dig ^ w_b_dig;
            ALU_OR:  w_dig = w_a_dig | w_b_dig;
            default: w_dig = w_add_dig;
        endcase
    end

    // Operands rotate rather than shift so A is back in place for CP after N digits.
    assign w_a_rot = WIDTH'({r_a, r_a} >> DIGIT);
    assign w_b_rot = WIDTH'({r_b, r_b} >> DIGIT);
    assign w_value = WIDTH'({w_dig, r_sum} >> DIGIT);

    // Half carry is tapped inside whichever digit holds bit WIDTH-5.
    assign w_h_arith = (r_cnt == CW'(H_DIG)) ? w_c[H_POS+1] : r_h;
    assign w_flag_h  = w_logic ? (r_op == ALU_AND) : (w_h_arith ^ r_sub);
    assign w_flag_v  = w_logic ? ~(^w_value[7:0]) : (w_c[DIGIT-1] ^ w_c[DIGIT]);
    assign w_flag_c  = w_logic ? 1'b0 : (w_c[DIGIT] ^ r_sub);
    assign w_f_next  = {w_value[WIDTH-1], (w_value == '0), 1'b0, w_flag_h,
                        1'b0, w_flag_v, r_sub, w_flag_c} | (r_f_in & 8'h28);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (bus.start) w_state_next = ST_RUN;
            ST_RUN:  if (w_last) w_state_next = ST_DONE;
            ST_DONE: w_state_next = bus.start ? ST_RUN : ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_op     <= '0;
            r_sub    <= 1'b0;
            r_carry  <= 1'b0;
            r_h      <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_sum    <= '0;
            r_f_in   <= '0;
            r_result <= '0;
            r_f_out  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_load) begin
                r_op    <= bus.op;
                r_sub   <= w_sub_in;
                r_a     <= bus.a_in;
                r_b     <= w_sub_in ? ~bus.operand : bus.operand;
                r_carry <= w_sub_in ^ w_cin_in;
                r_f_in  <= bus.f_in;
                r_cnt   <= '0;
                r_h     <= 1'b0;
            end else if (r_state == ST_RUN) begin
                r_a     <= w_a_rot;
                r_b     <= w_b_rot;
                r_sum   <= w_value;
                r_carry <= w_c[DIGIT];
                r_cnt   <= r_cnt + CW'(1);
                r_h     <= w_h_arith;
                if (w_last) begin
                    r_result <= (r_op == ALU_CP) ? w_a_rot : w_value;
                    r_f_out  <= w_f_next;
                end
            end
        end
    end

    assign bus.busy   = (r_state == ST_RUN);
    assign bus.done   = (r_state == ST_DONE);
    assign bus.result = r_result;
    assign bus.f_out  = r_f_out;
endmodule

// File: tb/tb_z80_alu_serial.sv
// Directed bench for z80_alu_serial: 8- and 16-bit instances at DIGIT 1, 4 and 8
// share stimulus; a negedge monitor logs every done pulse for the tests to inspect.
module tb_z80_alu_serial;
    localparam logic [2:0] ALU_ADD = 3'd0, ALU_ADC = 3'd1, ALU_SUB = 3'd2, ALU_SBC = 3'd3;
    localparam logic [2:0] ALU_AND = 3'd4, ALU_XOR = 3'd5, ALU_OR = 3'd6, ALU_CP = 3'd7;

    typedef struct packed {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [7:0]  fi;
        logic [15:0] res;
        logic [7:0]  fo;
    } vec_t;

    localparam vec_t V8 [9] = '{
        '{ALU_ADD, 16'h003A, 16'h00C6, 8'h00, 16'h0000, 8'h51},
        '{ALU_SBC, 16'h0000, 16'h0001, 8'h01, 16'h00FE, 8'h93},
        '{ALU_CP,  16'h0080, 16'h0001, 8'h28, 16'h0080, 8'h3E},
        '{ALU_XOR, 16'h0055, 16'h00AA, 8'h00, 16'h00FF, 8'h84},
        '{ALU_AND, 16'h00F0, 16'h003C, 8'h00, 16'h0030, 8'h14},
        '{ALU_OR,  16'h0000, 16'h0000, 8'hFF, 16'h0000, 8'h6C},
        '{ALU_SUB, 16'h007F, 16'h00FF, 8'h01, 16'h0080, 8'h87},
        '{ALU_ADD, 16'h007F, 16'h0001, 8'h01, 16'h0080, 8'h94},
        '{ALU_ADC, 16'h00FF, 16'h0000, 8'h01, 16'h0000, 8'h51}
    };
    string n8 [9] = '{"add", "sbc", "cp", "xor", "and", "or", "sub", "add_noc", "adc"};

    localparam vec_t V16 [4] = '{
        '{ALU_ADC, 16'h0FFF, 16'h0000, 8'h01, 16'h1000, 8'h10},
        '{ALU_SBC, 16'h8000, 16'h0001, 8'h00, 16'h7FFF, 8'h16},
        '{ALU_ADD, 16'h8000, 16'h8000, 8'h28, 16'h0000, 8'h6D},
        '{ALU_XOR, 16'h00FF, 16'h0100, 8'h00, 16'h01FF, 8'h04}
    };
    string n16 [4] = '{"adc16", "sbc16", "add16", "xor16"};

    string dname [6] = '{"w8d1", "w8d4", "w8d8", "w16d1", "w16d4", "w16d8"};
    int    lat   [6] = '{9, 3, 2, 17, 5, 3};

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        start8 = 1'b0;
    logic [2:0]  op8 = '0;
    logic [7:0]  a8 = '0, b8 = '0, f8 = '0;
    logic        start16 = 1'b0;
    logic [2:0]  op16 = '0;
    logic [15:0] a16 = '0, b16 = '0;
    logic [7:0]  f16 = '0;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [5:0]  mon_done;
    logic [5:0]  mon_busy;
    logic [15:0] mon_res [6];
    logic [7:0]  mon_f   [6];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar gi = 0; gi < 3; gi++) begin : g_w8
        localparam int D = (gi == 0) ? 1 : (gi == 1) ? 4 : 8;
        z80_alu_serial_if #(.WIDTH(8)) ifc ();
        assign ifc.start   = start8;
        assign ifc.op      = op8;
        assign ifc.a_in    = a8;
        assign ifc.operand = b8;
        assign ifc.f_in    = f8;
        z80_alu_serial #(.WIDTH(8), .DIGIT(D)) u_dut (.clk(clk), .reset(reset), .bus(ifc));
        assign mon_done[gi] = ifc.done;
        assign mon_busy[gi] = ifc.busy;
        assign mon_res[gi]  = {8'h00, ifc.result};
        assign mon_f[gi]    = ifc.f_out;
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_w16
        localparam int D = (gi == 0) ? 1 : (gi == 1) ? 4 : 8;
        z80_alu_serial_if #(.WIDTH(16)) ifc ();
        assign ifc.start   = start16;
        assign ifc.op      = op16;
        assign ifc.a_in    = a16;
        assign ifc.operand = b16;
        assign ifc.f_in    = f16;
        z80_alu_serial #(.WIDTH(16), .DIGIT(D)) u_dut (.clk(clk), .reset(reset), .bus(ifc));
        assign mon_done[gi+3] = ifc.done;
        assign mon_busy[gi+3] = ifc.busy;
        assign mon_res[gi+3]  = ifc.result;
        assign mon_f[gi+3]    = ifc.f_out;
    end

    // Done-pulse log: cycle number, result and flags of every pulse per instance.
    int          log_n   [6];
    int          log_cyc [6][64];
    logic [15:0] log_res [6][64];
    logic [7:0]  log_f   [6][64];

    always @(negedge clk) begin
        for (int k = 0; k < 6; k++) begin
            if (mon_done[k]) begin
                log_cyc[k][log_n[k] % 64] <= cyc;
                log_res[k][log_n[k] % 64] <= mon_res[k];
                log_f[k][log_n[k] % 64]   <= mon_f[k];
                log_n[k]                  <= log_n[k] + 1;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        $display("reset: expect busy=0 done=0 result=0 f_out=0");
        for (int k = 0; k < 6; k++) begin
            n_cmp++;
            if (mon_busy[k] !== 1'b0) begin n_bad++; $display("FAIL reset_busy %s: got %b want 0", dname[k], mon_busy[k]); end
            n_cmp++;
            if (mon_done[k] !== 1'b0) begin n_bad++; $display("FAIL reset_done %s: got %b want 0", dname[k], mon_done[k]); end
            n_cmp++;
            if (mon_res[k] !== 16'h0000) begin n_bad++; $display("FAIL reset_result %s: got %h want 0000", dname[k], mon_res[k]); end
            n_cmp++;
            if (mon_f[k] !== 8'h00) begin n_bad++; $display("FAIL reset_f_out %s: got %h want 00", dname[k], mon_f[k]); end
        end
    endtask

    task automatic test_w8_ops();
        vec_t v;
        int   t0;
        int   e;
        int   base [3];
        tick(1);
        for (int i = 0; i < 9; i++) begin
            v = V8[i];
            for (int k = 0; k < 3; k++) base[k] = log_n[k];
            op8 = v.op; a8 = v.a[7:0]; b8 = v.b[7:0]; f8 = v.fi;
            start8 = 1'b1;
            t0 = cyc;
            tick(1);
            start8 = 1'b0;
            tick(12);
            $display("w8 %s: a=%h operand=%h f_in=%h -> expect result=%h f_out=%h",
                     n8[i], v.a[7:0], v.b[7:0], v.fi, v.res[7:0], v.fo);
            for (int k = 0; k < 3; k++) begin
                e = base[k] % 64;
                n_cmp++;
                if (log_n[k] - base[k] !== 1) begin n_bad++; $display("FAIL %s_done_count %s: got %0d want 1", n8[i], dname[k], log_n[k] - base[k]); end
                n_cmp++;
                if (log_cyc[k][e] - t0 !== lat[k]) begin n_bad++; $display("FAIL %s_latency %s: got %0d want %0d", n8[i], dname[k], log_cyc[k][e] - t0, lat[k]); end
                n_cmp++;
                if (log_res[k][e] !== v.res) begin n_bad++; $display("FAIL %s_result %s: got %h want %h", n8[i], dname[k], log_res[k][e], v.res); end
                n_cmp++;
                if (log_f[k][e] !== v.fo) begin n_bad++; $display("FAIL %s_f_out %s: got %h want %h", n8[i], dname[k], log_f[k][e], v.fo); end
            end
        end
    endtask

    task automatic test_w16_ops();
        vec_t v;
        int   t0;
        int   e;
        int   base [6];
        for (int i = 0; i < 4; i++) begin
            v = V16[i];
            for (int k = 3; k < 6; k++) base[k] = log_n[k];
            op16 = v.op; a16 = v.a; b16 = v.b; f16 = v.fi;
            start16 = 1'b1;
            t0 = cyc;
            tick(1);
            start16 = 1'b0;
            tick(20);
            $display("w16 %s: a=%h operand=%h f_in=%h -> expect result=%h f_out=%h",
                     n16[i], v.a, v.b, v.fi, v.res, v.fo);
            for (int k = 3; k < 6; k++) begin
                e = base[k] % 64;
                n_cmp++;
                if (log_n[k] - base[k] !== 1) begin n_bad++; $display("FAIL %s_done_count %s: got %0d want 1", n16[i], dname[k], log_n[k] - base[k]); end
                n_cmp++;
                if (log_cyc[k][e] - t0 !== lat[k]) begin n_bad++; $display("FAIL %s_latency %s: got %0d want %0d", n16[i], dname[k], log_cyc[k][e] - t0, lat[k]); end
                n_cmp++;
                if (log_res[k][e] !== v.res) begin n_bad++; $display("FAIL %s_result %s: got %h want %h", n16[i], dname[k], log_res[k][e], v.res); end
                n_cmp++;
                if (log_f[k][e] !== v.fo) begin n_bad++; $display("FAIL %s_f_out %s: got %h want %h", n16[i], dname[k], log_f[k][e], v.fo); end
            end
        end
    endtask

    // XOR started at t0; SUB presented afterwards with a second start pulse at t0+3.
    // D4 takes it from DONE, D8 from IDLE, D1 ignores it while still running.
    task automatic test_back_to_back();
        int          t0;
        int          e;
        int          base  [3];
        int          x_cnt [3]    = '{1, 2, 2};
        int          x_cyc [3][2] = '{'{9, 0}, '{3, 6}, '{2, 5}};
        logic [15:0] x_res [2]    = '{16'h00FF, 16'h000F};
        logic [7:0]  x_f   [2]    = '{8'h84, 8'h12};
        tick(1);
        for (int k = 0; k < 3; k++) base[k] = log_n[k];
        op8 = ALU_XOR; a8 = 8'h55; b8 = 8'hAA; f8 = 8'h00;
        start8 = 1'b1;
        t0 = cyc;
        tick(1);
        op8 = ALU_SUB; a8 = 8'h10; b8 = 8'h01; f8 = 8'h00;
        start8 = 1'b0;
        tick(2);
        start8 = 1'b1;
        tick(1);
        start8 = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (mon_busy[1] !== 1'b1) begin n_bad++; $display("FAIL b2b_no_idle_gap w8d4: busy got %b want 1", mon_busy[1]); end
        n_cmp++;
        if (mon_busy[2] !== 1'b1) begin n_bad++; $display("FAIL b2b_restart w8d8: busy got %b want 1", mon_busy[2]); end
        tick(15);
        $display("b2b: xor 55^aa expect ff/84, then sub 10-01 expect 0f/12 (w8d1 keeps xor)");
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (log_n[k] - base[k] !== x_cnt[k]) begin n_bad++; $display("FAIL b2b_done_count %s: got %0d want %0d", dname[k], log_n[k] - base[k], x_cnt[k]); end
            for (int j = 0; j < x_cnt[k]; j++) begin
                e = (base[k] + j) % 64;
                n_cmp++;
                if (log_cyc[k][e] - t0 !== x_cyc[k][j]) begin n_bad++; $display("FAIL b2b_cycle%0d %s: got %0d want %0d", j, dname[k], log_cyc[k][e] - t0, x_cyc[k][j]); end
                n_cmp++;
                if (log_res[k][e] !== x_res[j]) begin n_bad++; $display("FAIL b2b_result%0d %s: got %h want %h", j, dname[k], log_res[k][e], x_res[j]); end
                n_cmp++;
                if (log_f[k][e] !== x_f[j]) begin n_bad++; $display("FAIL b2b_f_out%0d %s: got %h want %h", j, dname[k], log_f[k][e], x_f[j]); end
            end
        end
    endtask

    task automatic test_reset_midop();
        int base [6];
        tick(1);
        for (int k = 0; k < 6; k++) base[k] = log_n[k];
        op8 = ALU_ADD; a8 = 8'h3A; b8 = 8'hC6; f8 = 8'h00;
        op16 = ALU_ADD; a16 = 16'h8000; b16 = 16'h8000; f16 = 8'h00;
        start8 = 1'b1;
        start16 = 1'b1;
        tick(1);
        start8 = 1'b0;
        start16 = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            n_cmp++;
            if (mon_busy[k] !== 1'b1) begin n_bad++; $display("FAIL midop_busy_before %s: got %b want 1", dname[k], mon_busy[k]); end
        end
        tick(1);
        reset = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            n_cmp++;
            if (mon_busy[k] !== 1'b0) begin n_bad++; $display("FAIL midop_busy_after %s: got %b want 0", dname[k], mon_busy[k]); end
        end
        tick(20);
        $display("reset mid-op: expect no done, result=0 f_out=0");
        for (int k = 0; k < 6; k++) begin
            n_cmp++;
            if (log_n[k] !== base[k]) begin n_bad++; $display("FAIL midop_done_count %s: got %0d want 0", dname[k], log_n[k] - base[k]); end
            n_cmp++;
            if (mon_res[k] !== 16'h0000) begin n_bad++; $display("FAIL midop_result %s: got %h want 0000", dname[k], mon_res[k]); end
            n_cmp++;
            if (mon_f[k] !== 8'h00) begin n_bad++; $display("FAIL midop_f_out %s: got %h want 00", dname[k], mon_f[k]); end
        end
    endtask

    initial begin
        test_reset();
        test_w8_ops();
        test_w16_ops();
        test_back_to_back();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/z80_alu_serial.md
Name: z80_alu_serial

Overview:
- Multi-cycle, digit-serial Z80 ALU for ADD/ADC/SUB/SBC/AND/XOR/OR/CP.
- Processes WIDTH-bit operands one DIGIT-bit slice per clock, LSB digit first, as the real Z80 4-bit ALU does.
- WIDTH=8 serves the A-register ops. WIDTH=16 serves ADD/ADC/SBC HL,ss.
- Sits in the core execute stage, driven by the sequencer through a start/done handshake. Its flag results must match the z80fi instruction-spec modules bit for bit.

Parameters:
- WIDTH, 8, operand/result width; legal values are 8 and 16.
- DIGIT, 4, bits processed per cycle; must divide WIDTH; legal values are 1, 2, 4 and 8.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE and DONE.
- op  input  3  ALU function, using the ALU_FUNC_* encoding from z80.vh.
- a_in  input  WIDTH  left operand.
- operand  input  WIDTH  right operand.
- f_in  input  8  incoming F register; supplies carry-in, F5 and F3.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse when result and f_out become valid.
- result  output  WIDTH  value to write back.
- f_out  output  8  flags in the order {S,Z,5,H,3,V,N,C}.

Behaviour:
- Reset: state=IDLE; busy=0, done=0, result=0, f_out=0; digit counter=0. Reset overrides all other inputs, including in RUN; a reset during RUN abandons the operation and no done is produced.
- States:
  - IDLE, start=1 → RUN. On that edge, latch op, a_in, operand and f_in, clear the counter, and set the internal carry to the initial value.
  - RUN → RUN while counter < N-1, where N = WIDTH/DIGIT. Each edge computes one digit, stores it into the result shift register, updates the carry, and increments the counter.
  - RUN, counter == N-1 → DONE.
  - DONE: done=1 for exactly this cycle. In this cycle, start=1 → RUN with a fresh latch (back-to-back); otherwise → IDLE.
- Latency: start seen in cycle 0 gives done high in cycle N+1. Examples: WIDTH=8/DIGIT=4 → cycle 3; WIDTH=16/DIGIT=4 → cycle 5; WIDTH=8/DIGIT=8 → cycle 2.
- start during RUN is ignored; the latched operands are unaffected.
- result and f_out change only on the DONE-entry edge or on reset. They hold until the next completion, including across IDLE.
- Arithmetic:
  - sub = op in {SUB, SBC, CP}.
  - cin = C flag of f_in for ADC/SBC; 0 otherwise.
  - b = sub ? ~operand : operand.
  - Initial carry = sub XOR cin. Each digit is a + b + carry.
- Logical ops: AND, XOR, OR are computed bitwise per digit.
- result: a_in (latched) for CP; the computed value otherwise.
- Flags:
  - S = msb of the computed value, including for CP.
  - Z = computed value equals 0.
  - F5, F3 = copied from the latched f_in.
  - N = sub.
  - Arithmetic H = carry out of bit WIDTH-5; this is bit 3 for 8-bit and bit 11 for 16-bit. DIGIT=1, 2 or 8 must still capture it, which requires an internal tap when DIGIT=8.
  - Arithmetic V = signed overflow of a + b + initial carry (carry into msb XOR carry out of msb).
  - Arithmetic C = carry out of msb XOR sub, i.e. borrow for subtraction.
  - Logical: H = 1 for AND, 0 for XOR/OR. V = even parity of result[7:0]. C = 0.
- All flags are always computed. The sequencer decides which ones to commit; for example, ADD HL preserves S, Z and V.
- Width wrap: the final carry is discarded from result; there is no extension bit.

Test Plan:
- W8/D4, ADD, a=0x3A, operand=0xC6, f_in=0x00 → done in cycle 3; result=0x00; f_out=0x51 (Z, H, C set).
- W8/D4, SBC, a=0x00, operand=0x01, f_in=0x01 → result=0xFE; f_out=0x93 (S, H, N, C set).
- W8/D4, CP, a=0x80, operand=0x01, f_in=0x28 → result=0x80 (A unchanged); f_out=0x3E (F5, H, F3, V, N set; S=0, C=0).
- W16/D4, ADC, a=0x0FFF, operand=0x0000, f_in=0x01 → done in cycle 5; result=0x1000; f_out=0x10 (H only, carry from bit 11).
- W8/D4, XOR, a=0x55, operand=0xAA → result=0xFF; f_out=0x84 (S, V set). Then, with W8/D4 and a different op, start asserted in the DONE cycle → second done exactly 3 cycles later, with no IDLE gap.
- Corner cases:
  - start during RUN is ignored; the first operation's result is unchanged.
  - reset in cycle 1 of an operation → busy=0 next cycle; done never pulses; result and f_out read 0.
  - Each directed case repeated with DIGIT=1 and DIGIT=8 → identical result/f_out; latency N+1.
